// File: rtl/bounce_gen.sv
// bounce_gen: mechanical-switch emulator driving a raw contact signal.
// Accepts a clean level command and drives btn_out through 2N bounce phases
// (fixed or LFSR-derived count/width), then holds the target level for
// SETTLE_CYC cycles and pulses done.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle or in done cycle)
//   cmd_level         target settled level
//   rand_en           1: count/width from LFSR, 0: from cmd_bounces/cmd_width
//   cmd_bounces       fixed glitch count, clamped to BOUNCE_MAX
//   cmd_width         fixed phase width, 0 treated as 1
//   btn_out           emulated raw contact
//   busy              inverse of cmd_ready
//   done              one-cycle completion pulse
module bounce_gen #(
    parameter int unsigned BOUNCE_MAX = 7,
    parameter int unsigned WIDTH_MAX  = 15,
    parameter int unsigned SETTLE_CYC = 100,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_level,
    input  logic       rand_en,
    input  logic [3:0] cmd_bounces,
    input  logic [7:0] cmd_width,
    output logic       btn_out,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // one counter serves both bounce phases (<=255) and the settle window
    localparam int unsigned CNT_W     = (SETTLE_CYC > 256) ? $clog2(SETTLE_CYC) : 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [4:0]  N_MOD     = 5'(BOUNCE_MAX + 1);
    localparam logic [3:0]  N_CAP     = 4'(BOUNCE_MAX);
    localparam logic [7:0]  W_MOD     = 8'(WIDTH_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             btn_q, btn_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       phase_q, phase_d;
    logic [4:0]       last_q, last_d;
    logic             target_q, target_d;
    logic             rand_q, rand_d;
    logic [7:0]       width_q, width_d;

    logic             accept;
    logic [3:0]       rand_n, fix_n, sel_n;
    logic [7:0]       rand_w, fix_w, sel_w, next_w;

    // parameter selection for a new command and for each following phase
    always_comb begin
        rand_n = 4'({1'b0, lfsr_q[3:0]} % N_MOD);
        rand_w = 8'(lfsr_q[7:0] % W_MOD) + 8'd1;
        fix_n  = (cmd_bounces > N_CAP) ? N_CAP : cmd_bounces;
        fix_w  = (cmd_width == 8'd0) ? 8'd1 : cmd_width;
        sel_n  = rand_en ? rand_n : fix_n;
        sel_w  = rand_en ? rand_w : fix_w;
        next_w = rand_q ? rand_w : width_q;
        accept = cmd_valid && ready_q;
    end

    // next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        btn_d    = btn_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        last_d   = last_q;
        target_d = target_q;
        rand_d   = rand_q;
        width_d  = width_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (accept) begin
                    target_d = cmd_level;
                    rand_d   = rand_en;
                    width_d  = fix_w;
                    if (cmd_level == btn_q) begin
                        // nothing to bounce: complete on the next cycle
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        btn_d   = cmd_level;
                        ready_d = 1'b0;
                        if (sel_n == 4'd0) begin
                            state_d = SETTLE;
                            cnt_d   = SETTLE_LAST;
                        end else begin
                            state_d = BOUNCE;
                            cnt_d   = CNT_W'(sel_w - 8'd1);
                            phase_d = 5'd0;
                            last_d  = 5'({sel_n, 1'b0}) - 5'd1;
                        end
                    end
                end
            end
            BOUNCE: begin
                if (cnt_q == '0) begin
                    if (phase_q == last_q) begin
                        state_d = SETTLE;
                        btn_d   = target_q;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        phase_d = phase_q + 5'd1;
                        btn_d   = ~btn_q;
                        cnt_d   = CNT_W'(next_w - 8'd1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        busy_d = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_EFF;
            btn_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 5'd0;
            last_q   <= 5'd0;
            target_q <= 1'b0;
            rand_q   <= 1'b0;
            width_q  <= 8'd1;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            btn_q    <= btn_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            last_q   <= last_d;
            target_q <= target_d;
            rand_q   <= rand_d;
            width_q  <= width_d;
        end
    end

    assign btn_out   = btn_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
